// File: rtl/tm1640_frame_seq.sv
// ---------------------------------------------------------------------------
// tm1640_frame_seq
// Frame sequencer feeding a TM1640 byte/serial driver on a 9-digit
// 7-segment display. Each frame snapshots the digit codes, dot mask,
// brightness and enable, then streams 12 bytes over a valid/ready handshake:
//   0x40 (data cmd, STOP), 0xC0 (address cmd), 9 segment bytes (STOP after
//   the last), display-control cmd (STOP).
// Frames start on update, on refresh-counter expiry, or once after reset
// when AUTO_START is set. Requests arriving mid-frame merge into one
// follow-up frame that starts the cycle after frame_done.
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   digits      in   9 x 5-bit digit codes, digits[4:0] = digit 1 (addr 0xC0)
//   dots        in   decimal point per digit, bit0 = digit 1
//   bright      in   pulse-width setting 0..7
//   disp_on     in   1 = display on
//   update      in   single-cycle frame request
//   byte_data   out  byte for the driver
//   byte_valid  out  byte_data is valid
//   byte_last   out  driver sends STOP after this byte
//   byte_ready  in   driver accepts byte_data this cycle
//   busy        out  frame in progress
//   frame_done  out  1-cycle pulse after the final byte is accepted
// ---------------------------------------------------------------------------
module tm1640_frame_seq #(
    parameter int unsigned REFRESH_CYCLES = 32'd5_000_000,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [44:0] digits,
    input  logic [8:0]  dots,
    input  logic [2:0]  bright,
    input  logic        disp_on,
    input  logic        update,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic        byte_last,
    input  logic        byte_ready,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3,
        S_CTRL = 3'd4
    } state_t;

    // Segment byte: bit0=a .. bit6=g, bit7=dp.
    function automatic logic [7:0] seg_encode(input logic [4:0] code, input logic dp);
        logic [6:0] seg;
        case (code)
            5'd0:    seg = 7'h3F;
            5'd1:    seg = 7'h06;
            5'd2:    seg = 7'h5B;
            5'd3:    seg = 7'h4F;
            5'd4:    seg = 7'h66;
            5'd5:    seg = 7'h6D;
            5'd6:    seg = 7'h7D;
            5'd7:    seg = 7'h07;
            5'd8:    seg = 7'h7F;
            5'd9:    seg = 7'h6F;
            5'd10:   seg = 7'h77;
            5'd11:   seg = 7'h7C;
            5'd12:   seg = 7'h39;
            5'd13:   seg = 7'h5E;
            5'd14:   seg = 7'h79;
            5'd15:   seg = 7'h71;
            5'd17:   seg = 7'h40;
            default: seg = 7'h00;
        endcase
        return {dp, seg};
    endfunction

    state_t      state_r;
    logic [3:0]  idx_r;
    logic [44:0] digits_r;
    logic [8:0]  dots_r;
    logic [2:0]  bright_r;
    logic        disp_on_r;
    logic        pending_r;
    logic        auto_r;
    logic [31:0] refresh_cnt_r;

    logic        xfer_s;
    logic        refresh_hit_s;
    logic        start_s;
    logic [3:0]  next_idx_s;
    logic [4:0]  sel_code_s;
    logic        sel_dp_s;
    logic [7:0]  next_seg_s;
    logic [7:0]  ctrl_byte_s;

    // Handshake and frame-start decode.
    always_comb begin
        xfer_s        = byte_valid && byte_ready;
        refresh_hit_s = (REFRESH_CYCLES != 32'd0) && (state_r == S_IDLE) &&
                        (refresh_cnt_r == (REFRESH_CYCLES - 32'd1));
        start_s       = (state_r == S_IDLE) &&
                        (update || pending_r || auto_r || refresh_hit_s);
    end

    // Segment byte for the digit that follows the one on the bus
    // (digit 0 when leaving the address command).
    always_comb begin
        next_idx_s = (state_r == S_ADDR) ? 4'd0 : (idx_r + 4'd1);
        sel_code_s = 5'd0;
        sel_dp_s   = 1'b0;
        for (int i = 0; i < 9; i++) begin
            sel_code_s = (next_idx_s == i[3:0]) ? digits_r[i*5 +: 5] : sel_code_s;
            sel_dp_s   = (next_idx_s == i[3:0]) ? dots_r[i] : sel_dp_s;
        end
        next_seg_s  = seg_encode(sel_code_s, sel_dp_s);
        ctrl_byte_s = disp_on_r ? {5'b10001, bright_r} : 8'h80;
    end

    // Frame FSM with request merging, refresh timer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            idx_r         <= 4'd0;
            digits_r      <= 45'd0;
            dots_r        <= 9'd0;
            bright_r      <= 3'd0;
            disp_on_r     <= 1'b0;
            pending_r     <= 1'b0;
            auto_r        <= AUTO_START;
            refresh_cnt_r <= 32'd0;
            byte_data     <= 8'h00;
            byte_valid    <= 1'b0;
            byte_last     <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // A request seen while busy (including the final-transfer edge)
            // becomes one merged follow-up frame.
            if (start_s) begin
                pending_r <= 1'b0;
                auto_r    <= 1'b0;
            end else if (update && busy) begin
                pending_r <= 1'b1;
            end else begin
                pending_r <= pending_r;
            end

            if (start_s) begin
                refresh_cnt_r <= 32'd0;
            end else if ((REFRESH_CYCLES != 32'd0) && (state_r == S_IDLE)) begin
                refresh_cnt_r <= refresh_cnt_r + 32'd1;
            end else begin
                refresh_cnt_r <= refresh_cnt_r;
            end

            case (state_r)
                S_IDLE: begin
                    if (start_s) begin
                        digits_r   <= digits;
                        dots_r     <= dots;
                        bright_r   <= bright;
                        disp_on_r  <= disp_on;
                        byte_data  <= 8'h40;
                        byte_valid <= 1'b1;
                        byte_last  <= 1'b1;
                        busy       <= 1'b1;
                        state_r    <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (xfer_s) begin
                        byte_data <= 8'hC0;
                        byte_last <= 1'b0;
                        state_r   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (xfer_s) begin
                        byte_data <= next_seg_s;
                        byte_last <= 1'b0;
                        idx_r     <= 4'd0;
                        state_r   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (xfer_s) begin
                        if (idx_r == 4'd8) begin
                            byte_data <= ctrl_byte_s;
                            byte_last <= 1'b1;
                            state_r   <= S_CTRL;
                        end else begin
                            byte_data <= next_seg_s;
                            byte_last <= (next_idx_s == 4'd8);
                            idx_r     <= next_idx_s;
                        end
                    end
                end
                S_CTRL: begin
                    if (xfer_s) begin
                        byte_data  <= 8'h00;
                        byte_valid <= 1'b0;
                        byte_last  <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state_r    <= S_IDLE;
                    end
                end
                default: begin
                    byte_valid <= 1'b0;
                    byte_last  <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tm1640_frame_seq.sv
// ---------------------------------------------------------------------------
// tb_tm1640_frame_seq
// Scoreboard bench for tm1640_frame_seq. Directed stimulus pushes the
// hand-computed {last, byte} sequence of each frame into exp_q; a monitor
// pops and compares on every accepted byte and checks stability during
// stalls. A second instance with REFRESH_CYCLES=100 checks auto refresh.
// ---------------------------------------------------------------------------
module tb_tm1640_frame_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_n2;
    logic [44:0] digits;
    logic [8:0]  dots;
    logic [2:0]  bright;
    logic        disp_on;
    logic        update;
    logic        byte_ready;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_last;
    logic        busy;
    logic        frame_done;

    logic        update2 = 1'b0;
    logic        byte_ready2 = 1'b1;
    logic [7:0]  byte_data2;
    logic        byte_valid2;
    logic        byte_last2;
    logic        busy2;
    logic        frame_done2;

    logic [8:0]  exp_q[$];
    int          starts2[$];
    int          errs = 0;
    int          chks = 0;
    int          done_cnt = 0;
    int          xfer_cnt = 0;
    logic        rand_mode = 1'b0;

    always #5 clk = ~clk;

    tm1640_frame_seq #(.REFRESH_CYCLES(32'd0), .AUTO_START(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .digits(digits), .dots(dots), .bright(bright),
        .disp_on(disp_on), .update(update), .byte_data(byte_data),
        .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(byte_ready),
        .busy(busy), .frame_done(frame_done)
    );

    tm1640_frame_seq #(.REFRESH_CYCLES(32'd100), .AUTO_START(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n2), .digits(digits), .dots(dots), .bright(bright),
        .disp_on(disp_on), .update(update2), .byte_data(byte_data2),
        .byte_valid(byte_valid2), .byte_last(byte_last2), .byte_ready(byte_ready2),
        .busy(busy2), .frame_done(frame_done2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_byte(input logic last, input logic [7:0] data);
        exp_q.push_back({last, data});
    endtask

    // Frame whose nine data bytes are all the same value.
    task automatic push_uniform(input logic [7:0] d, input logic [7:0] ctrl);
        push_byte(1'b1, 8'h40);
        push_byte(1'b0, 8'hC0);
        for (int i = 0; i < 8; i++) push_byte(1'b0, d);
        push_byte(1'b1, d);
        push_byte(1'b1, ctrl);
    endtask

    task automatic pulse_update();
        @(posedge clk); #1 update = 1'b1;
        @(posedge clk); #1 update = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
        #1;
        if (done_cnt < target) begin
            chks++;
            errs++;
            $display("FAIL %s: timeout, frame_done count %0d expected %0d", name, done_cnt, target);
        end
    endtask

    // Random ready for stall testing.
    initial begin : ready_driver
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) byte_ready = 1'($urandom_range(0, 1));
        end
    end

    // Scoreboard monitor for the main instance.
    initial begin : monitor
        logic       pst;
        logic [8:0] pv;
        logic [8:0] e;
        pst = 1'b0;
        pv  = 9'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pst = 1'b0;
            end else begin
                if (pst) begin
                    check("stall_valid", 32'(byte_valid), 32'd1);
                    check("stall_hold", 32'({byte_last, byte_data}), 32'(pv));
                end
                pst = byte_valid && !byte_ready;
                pv  = {byte_last, byte_data};
                if (byte_valid && byte_ready) begin
                    xfer_cnt++;
                    if (exp_q.size() == 0) begin
                        chks++;
                        errs++;
                        $display("FAIL unexpected_byte: got last=%0d data=%0h, expected no transfer",
                                 byte_last, byte_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", 32'({byte_last, byte_data}), 32'(e));
                    end
                end
                if (frame_done) begin
                    done_cnt++;
                    check("done_not_busy", 32'(busy), 32'd0);
                end
            end
        end
    end

    // Records the cycle of each frame start of the refresh instance.
    initial begin : monitor2
        int   cyc2;
        logic pv2;
        cyc2 = 0;
        pv2  = 1'b0;
        forever begin
            @(negedge clk);
            cyc2++;
            if (!rst_n2) begin
                pv2 = 1'b0;
            end else begin
                if (byte_valid2 && !pv2) begin
                    starts2.push_back(cyc2);
                    check("refresh_first_byte", 32'(byte_data2), 32'h40);
                end
                pv2 = byte_valid2;
            end
        end
    end

    initial begin : stimulus
        int n;
        int base;
        rst_n      = 1'b0;
        rst_n2     = 1'b0;
        update     = 1'b0;
        byte_ready = 1'b1;
        digits     = {9{5'd8}};
        dots       = 9'h000;
        bright     = 3'd4;
        disp_on    = 1'b1;

        // Reset state
        #12;
        check("rst_data",  32'(byte_data),  32'h00);
        check("rst_valid", 32'(byte_valid), 32'd0);
        check("rst_last",  32'(byte_last),  32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_done",  32'(frame_done), 32'd0);

        // 1) AUTO_START frame, ready tied high
        push_uniform(8'h7F, 8'h8C);
        @(negedge clk); #1 rst_n = 1'b1;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (frame_done) begin
                n = i;
                break;
            end
        end
        check("t1_done_latency", 32'(n), 32'd13);
        wait_done(1, 20, "t1_done");
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // 2) Random stalls, same values
        rand_mode = 1'b1;
        push_uniform(8'h7F, 8'h8C);
        pulse_update();
        wait_done(2, 600, "t2_done");
        rand_mode  = 1'b0;
        byte_ready = 1'b1;
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // 3) Minus, blank, 'A' with dp, display off
        repeat (3) @(posedge clk);
        #1;
        digits  = {5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0, 5'h0A, 5'h10, 5'h11};
        dots    = 9'h004;
        bright  = 3'd5;
        disp_on = 1'b0;
        push_byte(1'b1, 8'h40);
        push_byte(1'b0, 8'hC0);
        push_byte(1'b0, 8'h40);
        push_byte(1'b0, 8'h00);
        push_byte(1'b0, 8'hF7);
        push_byte(1'b0, 8'h3F);
        push_byte(1'b0, 8'h06);
        push_byte(1'b0, 8'h5B);
        push_byte(1'b0, 8'h4F);
        push_byte(1'b0, 8'h66);
        push_byte(1'b1, 8'h6D);
        push_byte(1'b1, 8'h80);
        pulse_update();
        wait_done(3, 60, "t3_done");
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // 4) Mid-frame changes and three updates merge into one frame
        repeat (3) @(posedge clk);
        #1;
        digits  = {9{5'd1}};
        dots    = 9'h000;
        bright  = 3'd7;
        disp_on = 1'b1;
        push_uniform(8'h06, 8'h8F);
        push_uniform(8'hB9, 8'h8A);
        pulse_update();
        digits = {9{5'd12}};
        dots   = 9'h1FF;
        bright = 3'd2;
        pulse_update();
        pulse_update();
        pulse_update();
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (frame_done) begin
                n = 1;
                break;
            end
        end
        check("t4_first_done_seen", 32'(n), 32'd1);
        @(posedge clk); #1;
        check("t4_restart_valid", 32'(byte_valid), 32'd1);
        check("t4_restart_data",  32'(byte_data),  32'h40);
        check("t4_restart_busy",  32'(busy),       32'd1);
        wait_done(5, 60, "t4_done");
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // 5) No refresh on the main instance; refresh every 100 idle cycles on dut2
        repeat (250) @(negedge clk);
        #1;
        check("t5_no_refresh_done", 32'(done_cnt), 32'd5);
        check("t5_no_refresh_valid", 32'(byte_valid), 32'd0);
        @(negedge clk); #1 rst_n2 = 1'b1;
        for (int i = 0; i < 500 && starts2.size() < 3; i++) @(negedge clk);
        #1;
        check("t5_refresh_starts", 32'(starts2.size() >= 3), 32'd1);
        if (starts2.size() >= 3) begin
            check("t5_period1", 32'(starts2[1] - starts2[0]), 32'd112);
            check("t5_period2", 32'(starts2[2] - starts2[1]), 32'd112);
        end
        rst_n2 = 1'b0;

        // 6) Reset during DATA idx 4 aborts the frame; fresh frame afterwards
        push_uniform(8'hB9, 8'h8A);
        base = xfer_cnt;
        pulse_update();
        for (int i = 0; i < 40 && xfer_cnt < base + 6; i++) begin
            @(negedge clk); #1;
        end
        check("t6_reached_idx4", 32'(xfer_cnt - base), 32'd6);
        @(posedge clk); #2;
        check("t6_pre_rst_data", 32'(byte_data), 32'hB9);
        rst_n = 1'b0;
        #1;
        check("t6_rst_data",  32'(byte_data),  32'h00);
        check("t6_rst_valid", 32'(byte_valid), 32'd0);
        check("t6_rst_last",  32'(byte_last),  32'd0);
        check("t6_rst_busy",  32'(busy),       32'd0);
        check("t6_rst_done",  32'(frame_done), 32'd0);
        check("t6_remaining", 32'(exp_q.size()), 32'd6);
        exp_q.delete();
        push_uniform(8'hB9, 8'h8A);
        @(negedge clk); #1 rst_n = 1'b1;
        wait_done(6, 60, "t6_done");
        repeat (20) @(negedge clk);
        #1;
        check("t6_done_count", 32'(done_cnt), 32'd6);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
